// File: rtl/user_uart_pkg.sv
// Shared constants and FSM state encoding for the user-area UART transmitter.
// Imported by user_uart_tx; the parity state is only reachable under UART_TX_PARITY_EN.
package user_uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_MIN_DIV   = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/user_uart_fifo.sv
// Synchronous FIFO with a head-of-queue read port and an occupancy count.
// The count is one bit wider than the pointers so that full and empty stay distinct.
module user_uart_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     resetb,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q;
  logic [AW-1:0]    rdPtr_q;
  logic [AW:0]      count_q;
  logic             doPush;
  logic             doPop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;
  assign rdata_o = mem_q[rdPtr_q];
  assign level_o = count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + AW'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + AW'(1);
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (doPush) mem_q[wrPtr_q] <= wdata_i;
  end

endmodule

// File: rtl/user_uart_tx.sv
// Buffered UART transmitter: FIFO-fed, LSB-first, runtime bit period, registered tx.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1); otherwise frames are 8N1.
module user_uart_tx
  import user_uart_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DIV_W = 16
) (
  input  logic                   clock,
  input  logic                   resetb,
  input  logic                   enable,
  input  logic [DIV_W-1:0]       clk_div,
  input  logic                   wr_valid,
  input  logic [7:0]             wr_data,
  output logic                   wr_ready,
  output logic                   tx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);

  uart_state_e      state_q, state_d;
  logic [DIV_W-1:0] timer_q, timer_d;
  logic [DIV_W-1:0] period_q, period_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bitCnt_q, bitCnt_d;
  logic             tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic             fifoFull, fifoEmpty, pop, push, bitEnd;
  logic [7:0]       fifoRdata;
  logic [DIV_W-1:0] effDiv;

  assign push     = wr_valid && wr_ready;
  assign wr_ready = !fifoFull;
  assign effDiv   = (clk_div < DIV_W'(UART_MIN_DIV)) ? DIV_W'(UART_MIN_DIV) : clk_div;
  assign bitEnd   = (timer_q == DIV_W'(1));
  assign tx       = tx_q;
  assign busy     = (state_q != ST_IDLE) || (level != '0);

  user_uart_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
    .clock   (clock),
    .resetb  (resetb),
    .push_i  (push),
    .wdata_i (wr_data),
    .pop_i   (pop),
    .rdata_o (fifoRdata),
    .level_o (level),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  // A pop from IDLE or at the end of STOP both start a frame, so the frame load is shared.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    period_d = period_q;
    shift_d  = shift_q;
    bitCnt_d = bitCnt_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    pop      = 1'b0;
    tx_d     = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (enable && !fifoEmpty) pop = 1'b1;
      end
      ST_START: begin
        if (bitEnd) begin
          state_d = ST_DATA;
          timer_d = period_q;
        end else begin
          timer_d = timer_q - DIV_W'(1);
        end
      end
      ST_DATA: begin
        if (bitEnd) begin
          timer_d = period_q;
          if (bitCnt_q == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bitCnt_d = bitCnt_q + 3'd1;
            shift_d  = shift_q >> 1;
          end
        end else begin
          timer_d = timer_q - DIV_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bitEnd) begin
          state_d = ST_STOP;
          timer_d = period_q;
        end else begin
          timer_d = timer_q - DIV_W'(1);
        end
      end
`endif
      ST_STOP: begin
        if (bitEnd) begin
          if (enable && !fifoEmpty) pop = 1'b1;
          else                      state_d = ST_IDLE;
        end else begin
          timer_d = timer_q - DIV_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (pop) begin
      state_d  = ST_START;
      shift_d  = fifoRdata;
      period_d = effDiv;
      timer_d  = effDiv;
      bitCnt_d = '0;
`ifdef UART_TX_PARITY_EN
      parity_d = ^fifoRdata;
`endif
    end

    // tx is derived from the next state so the pad register changes on the same edge.
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q  <= ST_IDLE;
      timer_q  <= DIV_W'(UART_MIN_DIV);
      period_q <= DIV_W'(UART_MIN_DIV);
      shift_q  <= '0;
      bitCnt_q <= '0;
      tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      period_q <= period_d;
      shift_q  <= shift_d;
      bitCnt_q <= bitCnt_d;
      tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_user_uart_tx.sv
// Directed self-checking bench for user_uart_tx; follows UART_TX_PARITY_EN when defined.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_user_uart_tx;

  logic        clock;
  logic        resetb;
  logic        enable;
  logic [15:0] clk_div;
  logic        wr_valid;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic        tx;
  logic        busy;
  logic [3:0]  level;

  int checks   = 0;
  int failures = 0;

  user_uart_tx #(.DEPTH(8), .DIV_W(16)) dut (
    .clock    (clock),
    .resetb   (resetb),
    .enable   (enable),
    .clk_div  (clk_div),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .tx       (tx),
    .busy     (busy),
    .level    (level)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One-cycle write handshake starting at a falling edge.
  task automatic applyStimulus(input logic [7:0] data);
    wr_valid = 1'b1;
    wr_data  = data;
    @(negedge clock);
    wr_valid = 1'b0;
  endtask

  // Samples every cycle of one frame; the first sample is the first cycle of the start bit.
  task automatic checkFrame(input logic [7:0] data, input int period, input string tag);
    logic bits [11];
    int   nBits;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = data[i];
`ifdef UART_TX_PARITY_EN
    bits[9]  = ^data;
    bits[10] = 1'b1;
    nBits    = 11;
`else
    bits[9]  = 1'b1;
    bits[10] = 1'b1;
    nBits    = 10;
`endif
    for (int b = 0; b < nBits; b++) begin
      for (int c = 0; c < period; c++) begin
        @(negedge clock);
        checkOutput($sformatf("%s bit%0d cyc%0d", tag, b, c), {31'd0, tx}, {31'd0, bits[b]});
      end
    end
  endtask

  task automatic checkTxIdle(input int cycles, input string tag);
    logic sawLow;
    sawLow = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      if (tx !== 1'b1) sawLow = 1'b1;
    end
    checkOutput(tag, {31'd0, sawLow}, 32'd0);
  endtask

  initial begin
    resetb   = 1'b0;
    enable   = 1'b1;
    clk_div  = 16'd4;
    wr_valid = 1'b0;
    wr_data  = 8'h00;

    repeat (2) @(negedge clock);
    checkOutput("reset tx", {31'd0, tx}, 32'd1);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset level", {28'd0, level}, 32'd0);
    checkOutput("reset wr_ready", {31'd0, wr_ready}, 32'd1);
    resetb = 1'b1;
    @(negedge clock);
    checkOutput("post-reset tx", {31'd0, tx}, 32'd1);

    // Single 0xA5 frame at a 4-cycle bit period.
    applyStimulus(8'hA5);
    checkOutput("a5 level after write", {28'd0, level}, 32'd1);
    checkOutput("a5 tx before pop", {31'd0, tx}, 32'd1);
    checkOutput("a5 busy after write", {31'd0, busy}, 32'd1);
    checkFrame(8'hA5, 4, "a5");
    @(negedge clock);
    checkOutput("a5 busy after stop", {31'd0, busy}, 32'd0);
    checkOutput("a5 tx after stop", {31'd0, tx}, 32'd1);

    // Fill with enable low: nine writes offered, eight accepted.
    enable = 1'b0;
    for (int i = 0; i < 9; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'h10 + 8'(i);
      @(negedge clock);
    end
    wr_valid = 1'b0;
    checkOutput("fill level", {28'd0, level}, 32'd8);
    checkOutput("fill wr_ready", {31'd0, wr_ready}, 32'd0);
    checkOutput("fill tx idle", {31'd0, tx}, 32'd1);
    checkOutput("fill busy", {31'd0, busy}, 32'd1);
    enable = 1'b1;
    for (int j = 0; j < 8; j++) checkFrame(8'h10 + 8'(j), 4, $sformatf("burst%0d", j));
    @(negedge clock);
    checkOutput("burst busy after drain", {31'd0, busy}, 32'd0);
    checkOutput("burst level after drain", {28'd0, level}, 32'd0);
    checkTxIdle(8, "burst ninth byte dropped");

    // Divisor 0 behaves as 2; a mid-frame change only affects the next frame.
    enable  = 1'b0;
    clk_div = 16'd0;
    applyStimulus(8'h00);
    applyStimulus(8'hC3);
    checkOutput("div level queued", {28'd0, level}, 32'd2);
    enable = 1'b1;
    fork
      checkFrame(8'h00, 2, "div0");
      begin
        repeat (6) @(negedge clock);
        clk_div = 16'd6;
      end
    join
    checkFrame(8'hC3, 6, "div6");
    @(negedge clock);
    checkOutput("div busy after", {31'd0, busy}, 32'd0);

    // Odd-parity data byte at period 3.
    clk_div = 16'd3;
    applyStimulus(8'h07);
    checkFrame(8'h07, 3, "x07");
    @(negedge clock);
    checkOutput("x07 busy after", {31'd0, busy}, 32'd0);

    // Asynchronous reset during data bit 3 with three bytes queued.
    clk_div = 16'd4;
    enable  = 1'b0;
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    enable = 1'b1;
    repeat (18) @(negedge clock);
    checkOutput("rst pre tx low", {31'd0, tx}, 32'd0);
    resetb = 1'b0;
    #1;
    checkOutput("rst async tx", {31'd0, tx}, 32'd1);
    checkOutput("rst async level", {28'd0, level}, 32'd0);
    checkOutput("rst async busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
    resetb = 1'b1;
    checkTxIdle(30, "rst no frame after release");
    checkOutput("rst level after release", {28'd0, level}, 32'd0);

    // Enable dropped during the start bit: frame completes, queue stays.
    enable = 1'b0;
    applyStimulus(8'h5A);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    enable = 1'b1;
    fork
      checkFrame(8'h5A, 4, "endrop");
      begin
        @(negedge clock);
        enable = 1'b0;
      end
    join
    checkTxIdle(20, "endrop stays idle");
    checkOutput("endrop level", {28'd0, level}, 32'd2);
    checkOutput("endrop busy", {31'd0, busy}, 32'd1);
    enable = 1'b1;
    checkFrame(8'h11, 4, "resume0");
    checkFrame(8'h22, 4, "resume1");
    @(negedge clock);
    checkOutput("resume busy after", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/user_uart_tx.md
# user_uart_tx

Buffered 8N1 UART transmitter in the user project area. It drives a serial line on an `mprj_io` pad toward the testbench UART receiver, so firmware or LA-driven logic can stream status bytes that the bench decodes. Bytes enter through a valid/ready write port, queue in a small FIFO, and are serialized LSB-first at a runtime-programmable bit period.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, 2–64.
- `DIV_W`, 16: width of the bit-period divisor.
- `clock` in 1: single clock for all logic.
- `resetb` in 1: asynchronous, active-low reset.
- `enable` in 1: when low, no new frame starts.
- `clk_div` in DIV_W: bit period in clock cycles; values 0 and 1 are treated as 2.
- `wr_valid` in 1: write request.
- `wr_data` in 8: byte to send.
- `wr_ready` out 1: FIFO not full.
- `tx` out 1: serial output; idle high.
- `busy` out 1: frame in progress or FIFO non-empty.
- `level` out $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- Write handshake occurs on a rising edge where `wr_valid && wr_ready`. The byte is pushed.
- `wr_ready = (level != DEPTH)`. It is computed from occupancy only; a same-cycle pop does not raise it.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - **IDLE:** `tx`=1. If `enable` is high and the FIFO is non-empty, pop the head into the shift register, latch the effective `clk_div` into the bit timer, and go to START.
  - **START:** `tx`=0 for one bit period, then go to DATA.
  - **DATA:** send 8 bits LSB first, one bit period each, using a 3-bit bit counter. After bit 7, go to PARITY if enabled (see Configuration), otherwise go to STOP.
  - **PARITY:** `tx`=parity bit for one bit period, then go to STOP.
  - **STOP:** `tx`=1 for one bit period. Then:
    - if `enable` is high and the FIFO is non-empty, pop and go directly to START (back-to-back frames, no idle gap);
    - otherwise go to IDLE.
- Bit timer loads the latched period and counts down to 1. Reaching 1 ends the bit.
- `clk_div` is sampled only at frame start. Changing it mid-frame affects the next frame only.
- Deasserting `enable` mid-frame: the current frame completes; no further pops occur.
- Push and pop in the same cycle: `level` is unchanged and the data order is preserved.
- Pointers wrap modulo DEPTH. `level` distinguishes full from empty.
- `busy = (state != IDLE) || (level != 0)`.

## Timing
- Reset values:
  - `tx`=1, `busy`=0, `level`=0, `wr_ready`=1;
  - FSM in IDLE, pointers at 0.
- Reset asserted mid-frame: `tx` goes to 1 asynchronously and the FIFO contents are discarded.
- Latency: for a write handshake at edge N into an empty FIFO with `enable`=1, `level`=1 after N. IDLE pops at N+1. `tx` falls after edge N+1.
- Frame length is P×10 cycles, or P×11 with parity, where P is the effective period.
- `tx` is a registered output (glitch-free pad drive).

## Configuration
- `UART_TX_PARITY_EN` defined: a PARITY state is inserted after DATA. It sends even parity, i.e. the XOR of the 8 data bits, so the frame format is 8E1.
- Not defined: the PARITY state and its logic are absent, and the format is 8N1.

## Structure
- Package `user_uart_pkg` holds:
  - the FSM state encoding constants;
  - `UART_DATA_BITS`=8;
  - `UART_MIN_DIV`=2.
- Sub-module `user_uart_fifo` is a synchronous FIFO parameterized by DEPTH and width 8. It provides push/pop/level/full/empty and shares the same clock and reset.
- The top level contains the FSM, bit timer, shift register, and bit counter.

## Test plan
- `clk_div`=4, write 0xA5 → `tx` shows 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles. Total frame is 40 cycles. `busy` drops the cycle after the stop bit ends.
- `enable`=0, write 9 bytes with `wr_valid` held → 8 bytes are accepted, `level`=8, `wr_ready`=0. Set `enable`=1 → 8 frames go out back to back with no idle cycles, in write order.
- `clk_div`=0, write 0x00 → each bit is 2 cycles and the frame is 20 cycles. Change `clk_div` to 6 during DATA → the current frame keeps 2-cycle bits and the next frame uses 6-cycle bits.
- With `UART_TX_PARITY_EN` defined: write 0xA5 → parity bit 0. Write 0x07 → parity bit 1. Frames are 11 bit periods.
- Assert `resetb`=0 in bit 3 of a frame with 3 bytes queued → `tx`=1 immediately and `level`=0. After release, `tx` stays high and no frame starts.
- Deassert `enable` during the start bit with 2 bytes queued → the frame finishes, then the block stays in IDLE with `level`=2 and `busy`=1.
